// File: rtl/rsmp_pkg.sv
// Shared types and constants for the rejection sampler controller.
package rsmp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    EVAL,
    OUTPUT,
    DONE
  } state_e;

  localparam logic [63:0] PRNG_DEFAULT_SEED = 64'h9E37_79B9_7F4A_7C15;

  function automatic int fill_cycles(input int cand_w);
    return (cand_w + 31) / 32;
  endfunction

endpackage

// File: rtl/rejection_sampler_ctrl_if.sv
// Accepted-sample valid/ready stream.
interface rejection_sampler_ctrl_if #(
  parameter int CAND_W = 551
);

  logic              smp_valid;
  logic              smp_ready;
  logic [CAND_W-1:0] smp_data;

  modport master (
    output smp_valid,
    output smp_data,
    input  smp_ready
  );

  modport slave (
    input  smp_valid,
    input  smp_data,
    output smp_ready
  );

endinterface

// File: rtl/rsmp_xorshift64.sv
// xorshift64 generator; load has priority over step, zero seed is remapped.
module rsmp_xorshift64
  import rsmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] rnd
);

  logic [63:0] x_q;
  logic [63:0] x_d;
  logic [63:0] s0;
  logic [63:0] s1;
  logic [63:0] s2;

  always_comb begin
    s0  = x_q ^ (x_q << 13);
    s1  = s0 ^ (s0 >> 7);
    s2  = s1 ^ (s1 << 17);
    x_d = x_q;
    if (load) begin
      // an all-zero state would lock the generator at zero
      x_d = (seed == '0) ? PRNG_DEFAULT_SEED : seed;
    end else if (step) begin
      x_d = s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= PRNG_DEFAULT_SEED;
    end else begin
      x_q <= x_d;
    end
  end

  assign rnd = x_q;

endmodule

// File: rtl/rejection_sampler_ctrl.sv
// Builds random candidates, evaluates them on the external checker and
// streams the accepted ones with run statistics.
module rejection_sampler_ctrl
  import rsmp_pkg::*;
#(
  parameter int CAND_W    = 551,
  parameter int CHK_LAT   = 1,
  parameter int MAX_TRIES = 65536,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       seed,
  input  logic [15:0]       num_samples,
  output logic [CAND_W-1:0] cand_o,
  input  logic              chk_x_i,
  rejection_sampler_ctrl_if.master smp,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  accept_cnt,
  output logic [CNT_W-1:0]  reject_cnt
);

  localparam int FILL_CYC = fill_cycles(CAND_W);
  localparam int FC_W     = $clog2(FILL_CYC + 1);
  localparam int LAT_W    = $clog2(CHK_LAT + 1);
  localparam int TRY_W    = $clog2(MAX_TRIES + 1);

  state_e            state_q, state_d;
  logic [CAND_W-1:0] fill_q, fill_d, fill_nxt;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [TRY_W-1:0]  try_q, try_d;
  logic [15:0]       num_q, num_d;
  logic [CAND_W-1:0] cand_q, cand_d;
  logic [CAND_W-1:0] data_q, data_d;
  logic              tout_q, tout_d;
  logic [CNT_W-1:0]  acc_q, acc_d, acc_nxt;
  logic [CNT_W-1:0]  rej_q, rej_d;

  logic        fill_last;
  logic        eval_last;
  logic        try_hit;
  logic        acc_hit;
  logic        hs;
  logic        prng_load;
  logic        prng_step;
  logic        valid_o;
  logic [63:0] rnd;
  logic        unused_rnd_hi;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rsmp_xorshift64 u_prng (
    .clk  (clk),
    .rst  (rst),
    .load (prng_load),
    .seed (seed),
    .step (prng_step),
    .rnd  (rnd)
  );

  assign unused_rnd_hi = ^rnd[63:32];

  assign fill_nxt  = CAND_W'({fill_q, rnd[31:0]});
  assign fill_last = (fcnt_q == FC_W'(FILL_CYC - 1));
  assign eval_last = (lat_q == LAT_W'(CHK_LAT - 1));
  assign try_hit   = (try_q == TRY_W'(MAX_TRIES - 1));
  assign acc_nxt   = sat_inc(acc_q);
  assign acc_hit   = (acc_nxt == CNT_W'(num_q));
  assign hs        = (state_q == OUTPUT) && smp.smp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (num_samples == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (fill_last) state_d = EVAL;
      end
      EVAL: begin
        if (eval_last) begin
          if (chk_x_i)      state_d = OUTPUT;
          else if (try_hit) state_d = DONE;
          else              state_d = FILL;
        end
      end
      OUTPUT: begin
        if (hs) state_d = acc_hit ? DONE : FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      FILL, EVAL: busy = 1'b1;
      OUTPUT: begin
        busy    = 1'b1;
        valid_o = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    fill_d    = fill_q;
    fcnt_d    = fcnt_q;
    lat_d     = lat_q;
    try_d     = try_q;
    num_d     = num_q;
    cand_d    = cand_q;
    data_d    = data_q;
    tout_d    = tout_q;
    acc_d     = acc_q;
    rej_d     = rej_q;
    prng_load = 1'b0;
    prng_step = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          prng_load = 1'b1;
          num_d     = num_samples;
          tout_d    = 1'b0;
          acc_d     = '0;
          rej_d     = '0;
          try_d     = '0;
          fcnt_d    = '0;
        end
      end
      FILL: begin
        prng_step = 1'b1;
        fill_d    = fill_nxt;
        fcnt_d    = fcnt_q + FC_W'(1);
        if (fill_last) begin
          // checker input only moves here, so EVAL sees a stable vector
          cand_d = fill_nxt;
          fcnt_d = '0;
          lat_d  = '0;
        end
      end
      EVAL: begin
        lat_d = lat_q + LAT_W'(1);
        if (eval_last) begin
          if (chk_x_i) begin
            data_d = cand_q;
          end else begin
            rej_d = sat_inc(rej_q);
            try_d = try_q + TRY_W'(1);
            if (try_hit) tout_d = 1'b1;
          end
        end
      end
      OUTPUT: begin
        if (hs) begin
          acc_d = acc_nxt;
          try_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
      fcnt_q <= '0;
      lat_q  <= '0;
      try_q  <= '0;
      num_q  <= '0;
      cand_q <= '0;
      data_q <= '0;
      tout_q <= 1'b0;
      acc_q  <= '0;
      rej_q  <= '0;
    end else begin
      fill_q <= fill_d;
      fcnt_q <= fcnt_d;
      lat_q  <= lat_d;
      try_q  <= try_d;
      num_q  <= num_d;
      cand_q <= cand_d;
      data_q <= data_d;
      tout_q <= tout_d;
      acc_q  <= acc_d;
      rej_q  <= rej_d;
    end
  end

  assign cand_o        = cand_q;
  assign smp.smp_valid = valid_o;
  assign smp.smp_data  = data_q;
  assign timeout       = tout_q;
  assign accept_cnt    = acc_q;
  assign reject_cnt    = rej_q;

endmodule

// File: tb/tb_rejection_sampler_ctrl.sv
// Bench for rejection_sampler_ctrl: vector table, corner sequences and
// randomized runs checked against an xorshift reference model.
module tb_rejection_sampler_ctrl;

  localparam int CAND_W = 551;
  localparam int NW     = (CAND_W + 31) / 32;
  localparam int MAXT   = 65536;
  localparam int BUDGET = 20000;
  localparam logic [63:0] DEF_SEED = 64'h9E3779B97F4A7C15;

  typedef struct {
    logic [63:0] seed;
    logic [15:0] num;
    int          mode;
    int          pct;
    int          exp_acc;
    int          exp_rej;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              start_t;
  logic [63:0]       seed;
  logic [15:0]       num;
  logic [CAND_W-1:0] cand;
  logic [CAND_W-1:0] unused_cand_t;
  logic              chk;
  logic              busy, done, tout;
  logic              busy_t, done_t, tout_t;
  logic [31:0]       acc, rej, acc_t, rej_t;
  int                mode;
  logic [1:0]        pat;
  int                total = 0;
  int                bad = 0;
  logic [63:0]       mx;
  logic [CAND_W-1:0] exp_q[$];
  logic [CAND_W-1:0] rx_q[$];
  int                exp_rej;
  bit                exp_tmo;
  vec_t              tbl[5];

  rejection_sampler_ctrl_if #(.CAND_W(CAND_W)) smp ();
  rejection_sampler_ctrl_if #(.CAND_W(CAND_W)) smp_t ();

  assign smp_t.smp_ready = 1'b1;
  assign chk = (mode == 0)
            || (mode == 1 && cand[3:0] == 4'h5)
            || (mode == 3 && cand[1:0] == pat);

  always #5 clk = ~clk;

  rejection_sampler_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seed        (seed),
    .num_samples (num),
    .cand_o      (cand),
    .chk_x_i     (chk),
    .smp         (smp),
    .busy        (busy),
    .done        (done),
    .timeout     (tout),
    .accept_cnt  (acc),
    .reject_cnt  (rej)
  );

  rejection_sampler_ctrl #(.MAX_TRIES(8)) u_tmo (
    .clk         (clk),
    .rst         (rst),
    .start       (start_t),
    .seed        (seed),
    .num_samples (num),
    .cand_o      (unused_cand_t),
    .chk_x_i     (1'b0),
    .smp         (smp_t),
    .busy        (busy_t),
    .done        (done_t),
    .timeout     (tout_t),
    .accept_cnt  (acc_t),
    .reject_cnt  (rej_t)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_w(input string nm, input logic [CAND_W-1:0] act,
                         input logic [CAND_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    y ^= y << 13;
    y ^= y >> 7;
    y ^= y << 17;
    return y;
  endfunction

  // a candidate is NW words of 32 bits, oldest word most significant
  task automatic mdl_cand(output logic [CAND_W-1:0] c);
    logic [NW*32-1:0] w;
    w = '0;
    for (int i = 0; i < NW; i++) begin
      w  = {w[NW*32-33:0], mx[31:0]};
      mx = xs(mx);
    end
    c = w[CAND_W-1:0];
  endtask

  function automatic bit mdl_ok(input logic [CAND_W-1:0] c, input int m,
                                input logic [1:0] p);
    case (m)
      0:       return 1'b1;
      1:       return c[3:0] == 4'h5;
      3:       return c[1:0] == p;
      default: return 1'b0;
    endcase
  endfunction

  task automatic mdl_run(input logic [63:0] s, input int n, input int m,
                         input int maxt);
    logic [CAND_W-1:0] c;
    int tries;
    mx = (s == 64'd0) ? DEF_SEED : s;
    exp_q.delete();
    exp_rej = 0;
    exp_tmo = 1'b0;
    for (int k = 0; k < n && !exp_tmo; k++) begin
      tries = 0;
      while (1) begin
        mdl_cand(c);
        if (mdl_ok(c, m, pat)) begin
          exp_q.push_back(c);
          break;
        end
        exp_rej++;
        tries++;
        if (tries == maxt) begin
          exp_tmo = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic run_main(input logic [63:0] s, input logic [15:0] n,
                          input int m, input int pct, input int inj);
    int cyc;
    int first_v;
    int got;
    int n_exp;
    logic [CAND_W-1:0] e;
    mode = m;
    mdl_run(s, int'(n), m, MAXT);
    n_exp = exp_q.size();
    rx_q.delete();
    seed  = s;
    num   = n;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cyc     = 1;
    first_v = 0;
    got     = 0;
    if (n != 0) check("busy_after_start", 64'(busy), 64'd1);
    while (!done && cyc < BUDGET) begin
      if (cyc == inj) begin
        seed  = ~s;
        num   = 16'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      smp.smp_ready = ($urandom_range(99) < pct);
      if (smp.smp_valid) begin
        if (first_v == 0) first_v = cyc;
        if (smp.smp_ready) begin
          got++;
          rx_q.push_back(smp.smp_data);
          if (exp_q.size() == 0) begin
            check("extra_sample", 64'(got), 64'(n_exp));
          end else begin
            e = exp_q.pop_front();
            check_w("smp_data", smp.smp_data, e);
          end
          if (m == 1) check("nib5", 64'(smp.smp_data[3:0]), 64'h5);
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= BUDGET) check("run_budget", 64'(cyc), 64'(BUDGET - 1));
    check("done", 64'(done), 64'd1);
    check("busy_end", 64'(busy), 64'd0);
    check("valid_end", 64'(smp.smp_valid), 64'd0);
    check("timeout", 64'(tout), 64'(exp_tmo));
    check("accept_cnt", 64'(acc), 64'(n_exp));
    check("handshakes", 64'(got), 64'(n_exp));
    check("reject_cnt", 64'(rej), 64'(exp_rej));
    if (m == 0 && n != 0) check("latency", 64'(first_v), 64'd20);
    if (n == 0) check("zero_done_lat", 64'(cyc), 64'd1);
  endtask

  task automatic wait_valid(input string nm);
    int w;
    w = 0;
    while (!smp.smp_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    check(nm, 64'(smp.smp_valid), 64'd1);
  endtask

  task automatic bp_test();
    logic [CAND_W-1:0] held;
    mode = 0;
    mdl_run(64'h42, 2, 0, MAXT);
    smp.smp_ready = 1'b0;
    seed  = 64'h42;
    num   = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("bp_wait");
    held = smp.smp_data;
    check_w("bp_first", held, exp_q[0]);
    repeat (10) begin
      @(negedge clk);
      check_w("bp_stable", smp.smp_data, held);
      check("bp_valid", 64'(smp.smp_valid), 64'd1);
      check("bp_acc", 64'(acc), 64'd0);
    end
    smp.smp_ready = 1'b1;
    @(negedge clk);
    smp.smp_ready = 1'b0;
    check("bp_one_hs", 64'(acc), 64'd1);
    check("bp_valid_drop", 64'(smp.smp_valid), 64'd0);
    repeat (30) @(negedge clk);
    check("bp_single", 64'(acc), 64'd1);
    check("bp_second", 64'(smp.smp_valid), 64'd1);
    check_w("bp_second_data", smp.smp_data, exp_q[1]);
    smp.smp_ready = 1'b1;
    @(negedge clk);
    smp.smp_ready = 1'b0;
    check("bp_done", 64'(done), 64'd1);
    check("bp_acc2", 64'(acc), 64'd2);
  endtask

  task automatic tmo_test();
    int cyc;
    bit vseen;
    num     = 16'd5;
    seed    = 64'h77;
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    cyc     = 1;
    vseen   = 1'b0;
    while (!done_t && cyc < BUDGET) begin
      if (smp_t.smp_valid) vseen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("tmo_done", 64'(done_t), 64'd1);
    check("tmo_flag", 64'(tout_t), 64'd1);
    check("tmo_rej", 64'(rej_t), 64'd8);
    check("tmo_acc", 64'(acc_t), 64'd0);
    check("tmo_busy", 64'(busy_t), 64'd0);
    check("tmo_valid_seen", 64'(vseen), 64'd0);
    check("tmo_cycles", 64'(cyc), 64'(1 + 8 * (NW + 1)));
  endtask

  task automatic rst_output_test();
    mode = 0;
    smp.smp_ready = 1'b0;
    seed  = 64'h9;
    num   = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("ro_wait");
    smp.smp_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    smp.smp_ready = 1'b0;
    check("ro_valid", 64'(smp.smp_valid), 64'd0);
    check("ro_acc", 64'(acc), 64'd0);
    check("ro_busy", 64'(busy), 64'd0);
    check("ro_done", 64'(done), 64'd0);
    check_w("ro_data", smp.smp_data, '0);
  endtask

  initial begin
    tbl[0] = '{64'h1234,     16'd0, 0, 100, 0, 0};
    tbl[1] = '{64'h1,        16'd4, 0, 100, 4, 0};
    tbl[2] = '{64'h7,        16'd1, 0, 50,  1, 0};
    tbl[3] = '{64'hDEADBEEF, 16'd2, 1, 100, 2, -1};
    tbl[4] = '{64'h3,        16'd3, 1, 70,  3, -1};

    rst     = 1'b1;
    start   = 1'b1;
    start_t = 1'b1;
    seed    = 64'h5;
    num     = 16'd3;
    mode    = 0;
    pat     = 2'd0;
    smp.smp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tout", 64'(tout), 64'd0);
    check("rst_acc", 64'(acc), 64'd0);
    check("rst_rej", 64'(rej), 64'd0);
    check("rst_valid", 64'(smp.smp_valid), 64'd0);
    check_w("rst_cand", cand, '0);
    check_w("rst_data", smp.smp_data, '0);
    rst     = 1'b0;
    start   = 1'b0;
    start_t = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 5; i++) begin
      run_main(tbl[i].seed, tbl[i].num, tbl[i].mode, tbl[i].pct, 0);
      check("tbl_acc", 64'(acc), 64'(tbl[i].exp_acc));
      if (tbl[i].exp_rej >= 0) check("tbl_rej", 64'(rej), 64'(tbl[i].exp_rej));
    end

    bp_test();

    run_main(64'h5151, 16'd1, 0, 100, 5);

    run_main(64'd0, 16'd2, 0, 100, 0);
    mdl_run(DEF_SEED, 2, 0, MAXT);
    check("seed0_count", 64'(rx_q.size()), 64'd2);
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      check_w("seed0_data", rx_q[i], exp_q[i]);
    end

    tmo_test();

    for (int i = 0; i < 6; i++) begin
      pat = 2'($urandom_range(3));
      run_main({$urandom, $urandom}, 16'($urandom_range(3, 1)), 3, 60, 0);
    end

    rst_output_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
